// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches under a credit limit, tags
// in-order memory responses with their PC and queues them for the IF/ID stage.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4,
    input  logic        out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(2 * DEPTH) + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0] r_fetch_pc;
    entry_t      r_fifo [DEPTH];
    ptr_t        r_fifo_rd;
    ptr_t        r_fifo_wr;
    cnt_t        r_fifo_cnt;
    logic [31:0] r_tag [DEPTH];
    ptr_t        r_tag_rd;
    ptr_t        r_tag_wr;
    cnt_t        r_outstanding;
    cnt_t        r_drop;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_pc4;

    logic [CW:0] w_fill;
    logic        w_accept;
    logic        w_resp_drop;
    logic        w_resp_take;
    logic        w_resp_used;
    logic        w_pop;
    logic        w_has_head;
    entry_t      w_head;

    // Every issued request already owns a FIFO slot, so a response can always be pushed.
    assign w_fill         = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding} + {1'b0, r_drop};
    assign imem_req_valid = rst && !redirect_valid && (w_fill < DEPTH_W);
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_drop != '0);
    assign w_resp_take = imem_resp_valid && (r_drop == '0) && (r_outstanding != '0);
    assign w_resp_used = w_resp_drop || w_resp_take;

    assign w_has_head    = (r_fifo_cnt != '0);
    assign w_head        = r_fifo[r_fifo_rd];
    assign out_valid     = w_has_head && !redirect_valid;
    assign w_pop         = out_valid && out_ready;
    assign out_inst      = w_has_head ? w_head.inst        : r_hold_inst;
    assign out_pc        = w_has_head ? w_head.pc          : r_hold_pc;
    assign out_pc_plus_4 = w_has_head ? w_head.pc + 32'd4  : r_hold_pc4;

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_fifo_rd     <= '0;
            r_fifo_wr     <= '0;
            r_fifo_cnt    <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_hold_inst   <= '0;
            r_hold_pc     <= '0;
            r_hold_pc4    <= '0;
        end else begin
            // Shadow the visible head so the data buses keep their value once the FIFO empties.
            if (w_has_head) begin
                r_hold_inst <= w_head.inst;
                r_hold_pc   <= w_head.pc;
                r_hold_pc4  <= w_head.pc + 32'd4;
            end

            if (redirect_valid) begin
                r_fetch_pc    <= redirect_pc;
                r_fifo_rd     <= '0;
                r_fifo_wr     <= '0;
                r_fifo_cnt    <= '0;
                r_tag_rd      <= '0;
                r_tag_wr      <= '0;
                r_outstanding <= '0;
                // A response landing this cycle retires one of the requests being abandoned.
                r_drop        <= r_drop + r_outstanding - cnt_t'(w_resp_used);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_tag_wr   <= r_tag_wr + ptr_t'(1);
                end
                if (w_resp_take) begin
                    r_tag_rd  <= r_tag_rd + ptr_t'(1);
                    r_fifo_wr <= r_fifo_wr + ptr_t'(1);
                end
                if (w_pop) begin
                    r_fifo_rd <= r_fifo_rd + ptr_t'(1);
                end
                if (w_resp_drop) begin
                    r_drop <= r_drop - cnt_t'(1);
                end
                r_fifo_cnt    <= r_fifo_cnt + cnt_t'(w_resp_take) - cnt_t'(w_pop);
                r_outstanding <= r_outstanding + cnt_t'(w_accept) - cnt_t'(w_resp_take);
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy counters and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_tag_wr] <= r_fetch_pc;
        end
        if (w_resp_take && !redirect_valid) begin
            r_fifo[r_fifo_wr] <= '{pc: r_tag[r_tag_rd], inst: imem_resp_inst};
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a queued instruction-memory responder plus
// hand-derived expected PC streams for startup, stall, redirect, reset and wrap.
module tb_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic        out_ready;

    logic [31:0] pend [$];
    bit          resp_en;
    int          n_req;
    int          n_checks;
    int          n_fail;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_pc_plus_4   (out_pc_plus_4),
        .out_ready       (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory presents at most one in-order response per cycle, never in the acceptance cycle.
    task automatic prep();
        if (resp_en && pend.size() != 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = 32'h0;
        end
        #1;
    endtask

    task automatic adv();
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            n_req++;
        end
        @(negedge clk);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            prep();
            adv();
        end
    endtask

    task automatic wait_out(input string tag, input logic [31:0] exp_pc);
        bit          seen;
        logic [31:0] exp_pc4;
        seen    = 1'b0;
        exp_pc4 = exp_pc + 32'd4;
        for (int i = 0; i < 30 && !seen; i++) begin
            prep();
            if (out_valid) begin
                seen = 1'b1;
                check({tag, "_pc"}, out_pc, exp_pc);
                check({tag, "_pc4"}, out_pc_plus_4, exp_pc4);
                check({tag, "_inst"}, out_inst, inst_of(exp_pc));
            end
            adv();
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_inst = 32'h0;
        out_ready      = 1'b0;
        resp_en        = 1'b1;
        pend.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc4", out_pc_plus_4, 32'h0);
        rst   = 1'b1;
        n_req = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;

        // Startup and steady streaming
        do_reset();
        out_ready = 1'b1;
        prep();
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr", imem_req_addr, 32'h0);
        adv();
        prep();
        check("t1_no_bypass", 32'(out_valid), 32'd0);
        adv();
        for (int k = 0; k < 8; k++) begin
            prep();
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_pc", out_pc, 32'(k * 4));
            check("t1_pc4", out_pc_plus_4, 32'(k * 4 + 4));
            check("t1_inst", out_inst, inst_of(32'(k * 4)));
            adv();
        end

        // Consumer stall fills the credit window, then drains in order
        do_reset();
        step(10);
        check("t2_req_count", 32'(n_req), 32'd4);
        prep();
        check("t2_req_stop", 32'(imem_req_valid), 32'd0);
        check("t2_head_pc", out_pc, 32'h0);
        adv();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) wait_out("t2_drain", 32'(k * 4));

        // Redirect with three requests in flight
        do_reset();
        out_ready = 1'b1;
        resp_en   = 1'b0;
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        prep();
        check("t3_redir_req", 32'(imem_req_valid), 32'd0);
        check("t3_redir_out", 32'(out_valid), 32'd0);
        adv();
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        wait_out("t3_first", 32'h100);
        wait_out("t3_next", 32'h104);

        // Redirect coincident with a response and a ready consumer
        do_reset();
        resp_en = 1'b0;
        step(3);
        resp_en = 1'b1;
        step(1);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        prep();
        check("t4_redir_out", 32'(out_valid), 32'd0);
        check("t4_redir_req", 32'(imem_req_valid), 32'd0);
        adv();
        redirect_valid = 1'b0;
        prep();
        check("t4_flushed", 32'(out_valid), 32'd0);
        adv();
        wait_out("t4_first", 32'h200);
        wait_out("t4_next", 32'h204);

        // Reset pulse mid-stream with two requests outstanding
        do_reset();
        resp_en = 1'b0;
        step(2);
        resp_en = 1'b1;
        step(1);
        prep();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        check("t5_pre_pc", out_pc, 32'h0);
        adv();
        resp_en         = 1'b0;
        imem_resp_valid = 1'b0;
        rst             = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_rst_inst", out_inst, 32'h0);
        check("t5_rst_pc", out_pc, 32'h0);
        check("t5_rst_pc4", out_pc_plus_4, 32'h0);
        @(negedge clk);
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        resp_en        = 1'b1;
        prep();
        check("t5_restart_req", 32'(imem_req_valid), 32'd1);
        check("t5_restart_addr", imem_req_addr, 32'h0);
        adv();
        prep();
        check("t5_stale_ignored", 32'(out_valid), 32'd0);
        adv();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        wait_out("t5_first", 32'h0);
        wait_out("t5_next", 32'h4);

        // Back-to-back redirects: last target wins, drops accumulate
        do_reset();
        out_ready = 1'b1;
        resp_en   = 1'b0;
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step(1);
        redirect_pc = 32'h400;
        step(1);
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        wait_out("t6_b2b", 32'h400);

        // Address wrap-around
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        prep();
        check("t7_wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
        adv();
        wait_out("t7_top", 32'hFFFF_FFFC);
        wait_out("t7_zero", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of instruction FIFO entries and the maximum outstanding-request credit; legal values are 2, 4 and 8.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 redirect_valid  in  1  branch/jump redirect request from the EX/MEM stages.
REQ-006 redirect_pc  in  32  new fetch address, word-aligned.
REQ-007 imem_req_valid  out  1  fetch request to instruction memory.
REQ-008 imem_req_addr  out  32  fetch address.
REQ-009 imem_req_ready  in  1  memory accepts the request.
REQ-010 imem_resp_valid  in  1  instruction return; in order; at least 1 cycle after acceptance.
REQ-011 imem_resp_inst  in  32  returned instruction word.
REQ-012 out_valid  out  1  instruction available to the IF/ID register.
REQ-013 out_inst  out  32  instruction at FIFO head.
REQ-014 out_pc  out  32  address of out_inst.
REQ-015 out_pc_plus_4  out  32  out_pc + 4, modulo 2^32.
REQ-016 out_ready  in  1  IF/ID register consumes the head (stall when 0).

Function
REQ-017 SHALL hold fetch_pc, a FIFO of {pc, inst} with DEPTH entries, an in-order PC-tag queue of DEPTH entries, an outstanding counter and a drop counter.
REQ-018 Request acceptance SHALL occur on imem_req_valid && imem_req_ready.
- On acceptance: push fetch_pc to the tag queue, increment outstanding, and set fetch_pc += 4 with 32-bit wrap.
REQ-019 imem_req_valid SHALL be 1 only when all of the following hold:
- rst is high;
- redirect_valid is 0;
- fifo_count + outstanding + drop < DEPTH.
This guarantees the FIFO can never overflow.
REQ-020 imem_req_addr SHALL equal fetch_pc at all times.
REQ-021 An imem_resp_valid with drop > 0 SHALL decrement drop and be discarded.
REQ-022 Otherwise, imem_resp_valid SHALL:
- pop the tag queue;
- push {tag, imem_resp_inst} to the FIFO;
- decrement outstanding.
REQ-023 A response arriving with outstanding = 0 and drop = 0 SHALL be ignored, with no state change.
REQ-024 Output path:
- out_valid = (fifo_count != 0) && !redirect_valid.
- The head is popped on out_valid && out_ready.
- Latency from response to out_valid is exactly 1 cycle; there is no bypass.
REQ-025 Push and pop SHALL both take effect in the same cycle, including when the FIFO is full or empty; count is unchanged when both occur on a non-empty FIFO.
REQ-026 When redirect_valid is high at a clock edge, the following SHALL happen in that cycle:
- flush the FIFO and the tag queue;
- drop <= drop + outstanding, counting a response arriving in the same cycle as already consumed from that total;
- outstanding <= 0;
- fetch_pc <= redirect_pc.
No pop and no request occur in that cycle.
REQ-027 Back-to-back redirects SHALL each take effect; the last one wins for fetch_pc, and drops accumulate.
REQ-028 The drop and outstanding counters SHALL be wide enough for 2*DEPTH and shall never underflow.
REQ-029 The output data buses SHALL hold their last value while out_valid is 0; only out_valid is meaningful.

Reset
REQ-030 While rst is low, asynchronously, the block SHALL force:
- fetch_pc = RESET_PC;
- FIFO, tag queue, outstanding and drop cleared;
- imem_req_valid = 0, out_valid = 0;
- out_inst, out_pc and out_pc_plus_4 = 0.
REQ-031 Reset asserted mid-operation SHALL abandon all in-flight requests; responses after rst rises with zero outstanding are ignored per REQ-023.
REQ-032 The first request SHALL be presented on the first cycle after rst deasserts, with imem_req_addr = RESET_PC.

Verification
REQ-033 Memory always ready, 1-cycle response, out_ready = 1:
- out_pc sequence is 0, 4, 8, 12, ...;
- one instruction per cycle after 2-cycle startup;
- out_pc_plus_4 = out_pc + 4.
REQ-034 out_ready held 0 for 10 cycles, DEPTH = 4:
- exactly 4 requests are issued, then imem_req_valid = 0;
- FIFO holds pc 0..12;
- releasing out_ready drains in order with no loss or duplication.
REQ-035 Redirect to 32'h100 while 3 requests are outstanding:
- the next 3 responses are discarded;
- the next out_pc is 32'h100;
- out_valid = 0 in the redirect cycle.
REQ-036 Redirect coincident with a response and with an output pop:
- the response is discarded;
- no pop is counted;
- drop = outstanding - 1;
- subsequent stream starts at redirect_pc.
REQ-037 rst pulsed low for one cycle mid-stream with 2 outstanding:
- all outputs go to 0 immediately;
- stale responses are ignored;
- fetch restarts at RESET_PC.
REQ-038 Wrap-around: redirect_pc = 32'hFFFF_FFFC gives:
- out_pc sequence FFFF_FFFC then 0000_0000;
- out_pc_plus_4 = 0 for the first instruction.
